// File: rtl/mac_pkg.sv
// Shared constants for the product accumulator: FSM encoding and default sizes.
// Saturating adds are selected elsewhere with ACC_SATURATE_EN.
package mac_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_ACC_WIDTH = 12;
    localparam int DEF_COUNT     = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/sat_add.sv
// ACC_WIDTH-bit adder with carry-out; clamps to all-ones on carry when
// ACC_SATURATE_EN is defined, otherwise wraps modulo 2^ACC_WIDTH.
module sat_add #(
    parameter int ACC_WIDTH = 12
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 carry
);

    logic [ACC_WIDTH-1:0] raw;

    always_comb begin
        {carry, raw} = {1'b0, a} + {1'b0, b};
`ifdef ACC_SATURATE_EN
        sum = carry ? '1 : raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT multiplier products into one result with a sticky overflow flag.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int COUNT     = DEF_COUNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*WIDTH-1:0]   prod_in,
    input  logic                 prod_valid,
    input  logic                 start,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overflow
);

    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;
    logic                 carry;
    logic [CW-1:0]        count;

    sat_add #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_add (
        .a    (acc),
        .b    (ACC_WIDTH'(prod_in)),
        .sum  (sum),
        .carry(carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc   <= sum;
                        count <= count + CW'(1);
                        if (carry)
                            overflow <= 1'b1;
                        // last product of the result: publish the new sum directly
                        if (count == LAST) begin
                            acc_out   <= sum;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == ACCUM) || (state == DONE);

endmodule
